// File: rtl/cam_cfg_pkg.sv
// Shared types and constants for the OV7670 register-initialisation sequencer.
package cam_cfg_pkg;

    // Sequencer states, one per step of the ROM walk.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_ISSUE,
        ST_WAIT,
        ST_DELAY,
        ST_NEXT,
        ST_DONE,
        ST_ERROR
    } cfg_state_e;

    // ROM entry markers: all-ones ends the sequence, tag F0 in the
    // address byte turns the entry into an n-millisecond wait.
    localparam logic [15:0] CFG_END     = 16'hFFFF;
    localparam logic [7:0]  CFG_DLY_TAG = 8'hF0;

    // Number of config-clock cycles in one millisecond.
    function automatic int unsigned cycles_per_ms(input int unsigned t_cfg_clk_ns);
        return 1_000_000 / t_cfg_clk_ns;
    endfunction

endpackage

// File: rtl/cam_cfg_ms_timer.sv
// Loadable millisecond down-counter. A cycle prescaler wraps once per ms and
// decrements the ms count; o_done is high whenever the ms count is zero, so a
// load of zero finishes at once.
module cam_cfg_ms_timer
    import cam_cfg_pkg::*;
#(
    parameter int unsigned T_CFG_CLK = 10
) (
    input  logic       i_cfg_clk,
    input  logic       i_rstn,
    input  logic       i_load,
    input  logic [7:0] i_ms,
    output logic       o_done
);

    localparam int unsigned CYC_PER_MS = cycles_per_ms(T_CFG_CLK);
    localparam int unsigned CYC_W      = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
    localparam int unsigned MS_W       = $clog2(256);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CYC_PER_MS - 1);

    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [MS_W-1:0]  ms_q,  ms_d;

    // Next-state: reload on i_load, otherwise count cycles while ms is non-zero.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        cyc_d = cyc_q;
        ms_d  = ms_q;
        if (i_load) begin
            cyc_d = '0;
            ms_d  = i_ms;
        end else if (ms_q != '0) begin
            if (cyc_q == CYC_LAST) begin
                cyc_d = '0;
                ms_d  = ms_q - 1'b1;
            end else begin
                cyc_d = cyc_q + 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge i_cfg_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cyc_q <= '0;
            ms_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            cyc_q <= cyc_d;
            ms_q  <= ms_d;
        end
    end

    assign o_done = (ms_q == '0);

endmodule

// File: rtl/cam_cfg_sequencer.sv
// Walks the camera init ROM and turns each entry into an SCCB register write,
// a millisecond wait, or the end of the sequence. NACKed writes are retried
// up to MAX_RETRY extra times before the sequence stops in ERROR.
module cam_cfg_sequencer
    import cam_cfg_pkg::*;
#(
    parameter int unsigned T_CFG_CLK = 10,
    parameter int unsigned ROM_AW    = 8,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic              i_cfg_clk,
    input  logic              i_rstn,
    input  logic              i_cfg_init,
    output logic              o_cfg_done,
    output logic              o_cfg_busy,
    output logic              o_cfg_err,
    output logic [ROM_AW-1:0] o_rom_addr,
    input  logic [15:0]       i_rom_data,
    output logic              o_sccb_start,
    output logic [7:0]        o_sccb_addr,
    output logic [7:0]        o_sccb_data,
    input  logic              i_sccb_ready,
    input  logic              i_sccb_done,
    input  logic              i_sccb_nack
);

    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [ROM_AW-1:0]  ROM_LAST  = {ROM_AW{1'b1}};

    cfg_state_e          state_q, state_d;
    logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
    logic [7:0]          sccb_addr_q, sccb_addr_d;
    logic [7:0]          sccb_data_q, sccb_data_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic                tmr_load;
    logic                tmr_done;

    cam_cfg_ms_timer #(
        .T_CFG_CLK (T_CFG_CLK)
    ) u_ms_timer (
        .i_cfg_clk (i_cfg_clk),
        .i_rstn    (i_rstn),
        .i_load    (tmr_load),
        .i_ms      (i_rom_data[7:0]),
        .o_done    (tmr_done)
    );

    // Next-state, datapath updates and the single-cycle SCCB start strobe.
    always_comb begin
        state_d      = state_q;
        rom_addr_d   = rom_addr_q;
        sccb_addr_d  = sccb_addr_q;
        sccb_data_d  = sccb_data_q;
        retry_d      = retry_q;
        done_d       = done_q;
        busy_d       = busy_q;
        err_d        = err_q;
        tmr_load     = 1'b0;
        o_sccb_start = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (i_cfg_init) begin
                    rom_addr_d = '0;
                    retry_d    = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    state_d    = ST_FETCH;
                end
            end
            // ROM address is already applied; this cycle covers its read latency.
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                if (i_rom_data == CFG_END) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end else if (i_rom_data[15:8] == CFG_DLY_TAG) begin
                    tmr_load = 1'b1;
                    state_d  = ST_DELAY;
                end else begin
                    sccb_addr_d = i_rom_data[15:8];
                    sccb_data_d = i_rom_data[7:0];
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (i_sccb_ready) begin
                    o_sccb_start = 1'b1;
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_sccb_done) begin
                    if (!i_sccb_nack) begin
                        retry_d = '0;
                        state_d = ST_NEXT;
                    end else if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        err_d   = 1'b1;
                        done_d  = 1'b0;
                        busy_d  = 1'b0;
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_DELAY: begin
                if (tmr_done) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                // The last ROM address finishes the sequence instead of wrapping.
                if (rom_addr_q == ROM_LAST) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    rom_addr_d = rom_addr_q + 1'b1;
                    state_d    = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset abandons any write in flight.
    always_ff @(posedge i_cfg_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= ST_IDLE;
            rom_addr_q  <= '0;
            sccb_addr_q <= '0;
            sccb_data_q <= '0;
            retry_q     <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            sccb_addr_q <= sccb_addr_d;
            sccb_data_q <= sccb_data_d;
            retry_q     <= retry_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign o_rom_addr  = rom_addr_q;
    assign o_sccb_addr = sccb_addr_q;
    assign o_sccb_data = sccb_data_q;
    assign o_cfg_done  = done_q;
    assign o_cfg_busy  = busy_q;
    assign o_cfg_err   = err_q;

endmodule
